// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   // Data-bit count encoding as presented on i_nbits.
   typedef enum logic [1:0] {
      Nbits8 = 2'b00,
      Nbits7 = 2'b01,
      Nbits6 = 2'b10,
      Nbits5 = 2'b11
   } nbits_e;

   // Transmit FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } tx_state_e;

   // Shortest legal bit time in clocks; smaller divisors are clamped to this.
   localparam int unsigned MIN_CLKS_PER_BAUD = 2;

   // Number of data bits carried by a frame for a given encoding.
   function automatic logic [3:0] nbits_count(input nbits_e nb);
      return 4'd8 - {2'b00, nb};
   endfunction

endpackage

// File: rtl/uart_sfifo.sv
// Synchronous FIFO with registered occupancy; push is ignored when full, pop when empty.
module uart_sfifo
   import uart_pkg::*;
#(
   parameter int unsigned LGFIFO = 4,
   parameter int unsigned WIDTH  = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [WIDTH-1:0]  i_data,
   input  logic              i_pop,
   output logic [WIDTH-1:0]  o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LGFIFO:0]   o_fill
);

   localparam int unsigned DEPTH = 1 << LGFIFO;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [LGFIFO-1:0] wr_ptr_q;
   logic [LGFIFO-1:0] rd_ptr_q;
   logic [LGFIFO:0]   fill_q;
   logic              do_push;
   logic              do_pop;

   assign o_full  = (fill_q == (LGFIFO + 1)'(DEPTH));
   assign o_empty = (fill_q == '0);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_data  = mem[rd_ptr_q];
   assign o_fill  = fill_q;

   // Storage array; contents need no reset since the pointers gate every read.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= i_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the fill unchanged.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed, run-time frame format, CTS flow control, break.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned LGFIFO = 4,
   parameter int unsigned CLKS_W = 24
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [CLKS_W-1:0] i_clks_per_baud,
   input  logic [1:0]        i_nbits,
   input  logic              i_parity_en,
   input  logic              i_parity_odd,
   input  logic              i_two_stop,
   input  logic              i_hw_flow,
   input  logic              i_break,
   input  logic              i_wr_stb,
   input  logic [7:0]        i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_cts_n,
   output logic              o_uart_tx,
   output logic              o_busy,
   output logic [LGFIFO:0]   o_fifo_fill,
   output logic              o_txfifo_int
);

   localparam int unsigned       DEPTH    = 1 << LGFIFO;
   localparam logic [CLKS_W-1:0] MIN_CLKS = CLKS_W'(MIN_CLKS_PER_BAUD);

   tx_state_e         state_q;
   logic [CLKS_W-1:0] cnt_q;
   logic [CLKS_W-1:0] clks_q;
   logic [CLKS_W-1:0] clks_eff;
   logic [CLKS_W-1:0] reload;
   logic [7:0]        shreg_q;
   logic [3:0]        nbits_q;
   logic [3:0]        bits_left_q;
   logic              par_en_q;
   logic              two_stop_q;
   logic              stop_left_q;
   logic              parity_q;
   logic              guard_q;
   logic              tx_q;
   logic              busy_q;
   logic              cts_s1_q;
   logic              cts_s2_q;
   logic              cts_ok;
   logic              bit_end;
   logic              stop_end;
   logic              frame_slot;
   logic              break_go;
   logic              start_frame;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_data;
   logic [LGFIFO:0]   fifo_fill;

   uart_sfifo #(
      .LGFIFO (LGFIFO),
      .WIDTH  (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (i_wr_stb),
      .i_data  (i_wr_data),
      .i_pop   (start_frame),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_fill  (fifo_fill)
   );

   assign clks_eff = (i_clks_per_baud < MIN_CLKS) ? MIN_CLKS : i_clks_per_baud;
   assign reload   = clks_q - 1'b1;
   assign bit_end  = (cnt_q == '0);
   assign cts_ok   = !i_hw_flow || !cts_s2_q;

   // A new frame or a break may begin from IDLE or straight out of the last stop bit.
   assign stop_end    = (state_q == StStop) && bit_end && !stop_left_q;
   assign frame_slot  = (state_q == StIdle) || stop_end;
   assign break_go    = frame_slot && i_break;
   assign start_frame = frame_slot && !i_break && !fifo_empty && cts_ok;

   assign o_wr_ready   = !fifo_full;
   assign o_fifo_fill  = fifo_fill;
   assign o_txfifo_int = (fifo_fill < (LGFIFO + 1)'(DEPTH / 2));
   assign o_uart_tx    = tx_q;
   assign o_busy       = busy_q;

   // Two-flop synchroniser for the asynchronous CTS pin; resets to "not clear".
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cts_s1_q <= 1'b1;
         cts_s2_q <= 1'b1;
      end else begin
         cts_s1_q <= i_cts_n;
         cts_s2_q <= cts_s1_q;
      end
   end

   // Transmit FSM with baud down-counter, shift register and registered line/busy outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         clks_q      <= MIN_CLKS;
         shreg_q     <= '0;
         nbits_q     <= 4'd8;
         bits_left_q <= '0;
         par_en_q    <= 1'b0;
         two_stop_q  <= 1'b0;
         stop_left_q <= 1'b0;
         parity_q    <= 1'b0;
         guard_q     <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else if (break_go) begin
         state_q <= StBreak;
         guard_q <= 1'b0;
         clks_q  <= clks_eff;
         cnt_q   <= '0;
         tx_q    <= 1'b0;
         busy_q  <= 1'b1;
      end else if (start_frame) begin
         // Every config input is latched here so mid-frame changes cannot corrupt the frame.
         state_q    <= StStart;
         shreg_q    <= fifo_data;
         nbits_q    <= nbits_count(nbits_e'(i_nbits));
         par_en_q   <= i_parity_en;
         two_stop_q <= i_two_stop;
         parity_q   <= i_parity_odd;
         clks_q     <= clks_eff;
         cnt_q      <= clks_eff - 1'b1;
         tx_q       <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            StStart: begin
               if (!bit_end) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q       <= reload;
                  state_q     <= StData;
                  tx_q        <= shreg_q[0];
                  parity_q    <= parity_q ^ shreg_q[0];
                  shreg_q     <= {1'b0, shreg_q[7:1]};
                  bits_left_q <= nbits_q - 4'd1;
               end
            end
            StData: begin
               if (!bit_end) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q <= reload;
                  if (bits_left_q != '0) begin
                     tx_q        <= shreg_q[0];
                     parity_q    <= parity_q ^ shreg_q[0];
                     shreg_q     <= {1'b0, shreg_q[7:1]};
                     bits_left_q <= bits_left_q - 4'd1;
                  end else if (par_en_q) begin
                     state_q <= StParity;
                     tx_q    <= parity_q;
                  end else begin
                     state_q     <= StStop;
                     tx_q        <= 1'b1;
                     stop_left_q <= two_stop_q;
                  end
               end
            end
            StParity: begin
               if (!bit_end) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q       <= reload;
                  state_q     <= StStop;
                  tx_q        <= 1'b1;
                  stop_left_q <= two_stop_q;
               end
            end
            StStop: begin
               if (!bit_end) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (stop_left_q) begin
                  cnt_q       <= reload;
                  stop_left_q <= 1'b0;
               end else begin
                  state_q <= StIdle;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            StBreak: begin
               // Hold the line low while requested, then one mark bit time before IDLE.
               if (!guard_q) begin
                  if (!i_break) begin
                     guard_q <= 1'b1;
                     cnt_q   <= reload;
                     tx_q    <= 1'b1;
                  end
               end else if (!bit_end) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  guard_q <= 1'b0;
                  state_q <= StIdle;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an internal transmit FIFO, run-time selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits), CTS hardware flow control and break generation. It succeeds the fixed 8N1 transmit path of the current Wishbone UART and sits between the bus register front-end and the `o_uart_tx` pin. It is driven by a simple write strobe/ready interface and static configuration inputs.

## Interface
Parameters:
- `LGFIFO`, default 4: log2 of FIFO depth (depth = 16); legal range 1–10.
- `CLKS_W`, default 24: width of the baud divisor.

Ports:
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_clks_per_baud`  in  CLKS_W  clocks per bit. Values below 2 are treated as 2.
- `i_nbits`  in  2  data bits: 00=8, 01=7, 10=6, 11=5.
- `i_parity_en`  in  1  enable the parity bit.
- `i_parity_odd`  in  1  1=odd parity, 0=even parity.
- `i_two_stop`  in  1  send two stop bits.
- `i_hw_flow`  in  1  honour `i_cts_n`.
- `i_break`  in  1  request a break condition.
- `i_wr_stb`  in  1  push request.
- `i_wr_data`  in  8  byte to push. Only the low nbits are sent.
- `o_wr_ready`  out  1  FIFO not full.
- `i_cts_n`  in  1  asynchronous clear-to-send, active low.
- `o_uart_tx`  out  1  serial line. Idle level is 1.
- `o_busy`  out  1  a frame or break is in progress.
- `o_fifo_fill`  out  LGFIFO+1  FIFO occupancy.
- `o_txfifo_int`  out  1  high when fill < depth/2.

## Operation
- Push: the push is accepted when `i_wr_stb && o_wr_ready`. `o_wr_ready = (fill != depth)`. A strobe with ready low is dropped, and `o_fifo_fill` does not change.
- Push and pop in the same cycle leave fill unchanged. When the FIFO is full, ready is low, so a push is not accepted even if a pop occurs that cycle.
- `i_cts_n` passes through a 2-flop synchroniser to give `cts_ok`. When `i_hw_flow` is 0, `cts_ok` is forced to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → BREAK when `i_break` is 1. Break has priority over a pending frame.
  - IDLE → START when the FIFO is not empty and `cts_ok`. On this transition the FSM pops one byte and latches every config input for the whole frame.
  - START → DATA after one bit time.
  - DATA → PARITY, or → STOP when parity is disabled, after nbits bit times. Data is sent LSB first.
  - PARITY → STOP after one bit time. The parity bit is the XOR of the sent data bits, inverted when odd parity is selected.
  - STOP → IDLE after 1 or 2 bit times.
  - BREAK → IDLE one bit time after `i_break` falls. This bit time is a mark guard with `o_uart_tx` = 1.
- `o_uart_tx` per state: 0 in START and BREAK; data or parity bit in DATA/PARITY; 1 in STOP and IDLE, and during the BREAK guard.
- Effect of changes mid-frame:
  - Deasserting CTS or changing config never truncates the current frame.
  - Asserting `i_break` mid-frame takes effect at the next IDLE.
- `o_busy` is 1 in every state except IDLE.

## Timing
- Reset values: `o_uart_tx`=1, `o_busy`=0, `o_fifo_fill`=0, `o_wr_ready`=1, `o_txfifo_int`=1. FSM returns to IDLE, the baud counter is cleared and the FIFO pointers are zeroed. A reset mid-frame aborts the frame, and the line is high the cycle after reset.
- Bit time: every bit lasts exactly `max(i_clks_per_baud,2)` cycles, counted by a down-counter reloaded at each bit boundary.
- Latency: a push in cycle N into an empty FIFO with the FSM IDLE and `cts_ok` high gives a pop in N+1 and `o_uart_tx`=0 from N+2.
- After a CTS edge on the pin, `cts_ok` changes 2 cycles later.
- Back-to-back frames: when the FIFO is non-empty at the end of STOP, START follows immediately with no extra idle cycle.
- Frame length: 1 + nbits + parity + stop bits, for 7–12 bit times total.
- The FIFO is registered, and fill updates one cycle after a push or pop.

## Structure
- `uart_pkg` holds:
  - the `nbits_e` encoding (8/7/6/5 bits);
  - the `tx_state_e` enum;
  - the `MIN_CLKS_PER_BAUD = 2` constant.
- Sub-module `uart_sfifo` (parameter `LGFIFO`, width 8) provides a synchronous FIFO with push/pop, full, empty and fill. The FSM, baud counter, shift register and synchroniser stay in `uart_tx_param`.

## Test plan
- 8N1, divisor 4, push 0xA5:
  - `o_uart_tx` starts at cycle N+2 and sends 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `o_busy` falls after 40 cycles.
- 7 data bits, odd parity, 2 stop bits, push 0x83: the line carries 0; 1,1,0,0,0,0,0; parity 1; then 1,1. Bit 7 is not sent.
- Fill to 16, push a 17th byte:
  - ready is 0 and the 17th byte is dropped; fill stays 16.
  - When one more frame starts, fill goes to 15 and `o_txfifo_int` rises at fill 7.
- `i_hw_flow`=1 with `i_cts_n`=1 and 3 bytes queued: the line stays idle. Dropping CTS mid-second-frame completes that frame, then no third frame starts.
- Assert `i_break` during DATA: the frame completes, then `o_uart_tx` is 0 until `i_break` falls, followed by one mark bit time before the next START.
- Assert `i_reset` for 1 cycle mid-DATA: the next cycle shows `o_uart_tx`=1, fill=0 and `o_busy`=0.
